// File: rtl/io_bus_controller_if.sv
// ---------------------------------------------------------------------------
// io_bus_controller_if
//
// Bundles the request/response handshake between the CPU execute stage and
// the IO bus controller, together with the PROM port and the external device
// port that the controller drives.
//
// Signal groups:
//   req_*   : CPU request (valid/ready handshake, write flag, device id, data)
//   resp_*  : single-cycle response strobe with data and error flag
//   rom_*   : registered PROM address out, PROM data back one cycle later
//   ext_*   : external device request, completed by ext_ack with ext_rdata
//
// Modports:
//   slave  : the controller side
//   master : the CPU / environment side
// ---------------------------------------------------------------------------
interface io_bus_controller_if #(
    parameter int DATA_W     = 32,
    parameter int DEV_ID_W   = 8,
    parameter int ROM_ADDR_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [DEV_ID_W-1:0]   req_dev;
    logic [DATA_W-1:0]     req_data;

    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_data;
    logic                  resp_err;

    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0]     rom_data;

    logic                  ext_valid;
    logic                  ext_write;
    logic [DEV_ID_W-1:0]   ext_dev;
    logic [DATA_W-1:0]     ext_data;
    logic                  ext_ack;
    logic [DATA_W-1:0]     ext_rdata;

    modport slave (
        input  req_valid, req_write, req_dev, req_data,
        output req_ready,
        output resp_valid, resp_data, resp_err,
        output rom_addr,
        input  rom_data,
        output ext_valid, ext_write, ext_dev, ext_data,
        input  ext_ack, ext_rdata
    );

    modport master (
        output req_valid, req_write, req_dev, req_data,
        input  req_ready,
        input  resp_valid, resp_data, resp_err,
        input  rom_addr,
        output rom_data,
        input  ext_valid, ext_write, ext_dev, ext_data,
        output ext_ack, ext_rdata
    );
endinterface

// File: rtl/io_bus_controller.sv
// ---------------------------------------------------------------------------
// io_bus_controller
//
// Accepts one CPU IO request at a time and routes it to one of four device
// classes: on-chip PROM, console loopback, a bank of local output latches,
// or the external device port (ack handshake with optional timeout).
//
// Ports:
//   clk        : system clock, all activity on the rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : io_bus_controller_if.slave (request, response, PROM and
//                external device signals)
//   latch_out  : latch bank contents, latch i at [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module io_bus_controller #(
    parameter int DATA_W     = 32,
    parameter int DEV_ID_W   = 8,
    parameter int ROM_ADDR_W = 16,
    parameter int PROM_ID    = 2,
    parameter int CONSDEV_ID = 3,
    parameter int LATCH_BASE = 16,
    parameter int NUM_LATCH  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    io_bus_controller_if.slave          bus,
    output logic [NUM_LATCH*DATA_W-1:0] latch_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROM_RD   = 2'd1,
        EXT_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    // Counter only ever needs to hold 0..TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     latch_q [NUM_LATCH];
    logic [DATA_W-1:0]     latch_d [NUM_LATCH];
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_W-1:0]     resp_data_q, resp_data_d;
    logic                  ext_valid_q, ext_valid_d;
    logic                  ext_write_q, ext_write_d;
    logic [DEV_ID_W-1:0]   ext_dev_q, ext_dev_d;
    logic [DATA_W-1:0]     ext_data_q, ext_data_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept;
    logic                  hit_prom;
    logic                  hit_cons;
    logic                  hit_latch;
    logic [31:0]           dev_wide;
    logic [DEV_ID_W-1:0]   latch_idx;
    logic [DATA_W-1:0]     latch_rd;
    logic                  to_expire;

    assign accept = bus.req_valid && (state_q == IDLE);

    // Decode with fixed priority PROM > console > latch bank > external.
    // The bank range check is done in 32 bits so LATCH_BASE+NUM_LATCH cannot
    // wrap in DEV_ID_W bits and alias low ids into the bank.
    assign dev_wide  = 32'(bus.req_dev);
    assign hit_prom  = (bus.req_dev == DEV_ID_W'(PROM_ID));
    assign hit_cons  = !hit_prom && (bus.req_dev == DEV_ID_W'(CONSDEV_ID));
    assign hit_latch = !hit_prom && !hit_cons &&
                       (dev_wide >= 32'(LATCH_BASE)) &&
                       (dev_wide <  32'(LATCH_BASE + NUM_LATCH));
    assign latch_idx = bus.req_dev - DEV_ID_W'(LATCH_BASE);

    assign to_expire = (TIMEOUT > 0) && (cnt_q == TO_LAST);

    // Read mux over the latch bank, selected by the bank-relative index.
    always_comb begin
        latch_rd = '0;
        for (int i = 0; i < NUM_LATCH; i++) begin
            if (latch_idx == DEV_ID_W'(i)) begin
                latch_rd = latch_q[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit_prom) begin
                        state_d = bus.req_write ? RESP : ROM_RD;
                    end else if (hit_cons || hit_latch) begin
                        state_d = RESP;
                    end else begin
                        state_d = EXT_WAIT;
                    end
                end
            end
            ROM_RD:   state_d = RESP;
            EXT_WAIT: begin
                if (bus.ext_ack || to_expire) begin
                    state_d = RESP;
                end
            end
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output / datapath logic. Every response register is loaded on the edge
    // that enters RESP, so resp_valid is high exactly while state is RESP.
    // A simultaneous ack and timeout resolves in favour of the ack.
    always_comb begin
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        ext_valid_d  = ext_valid_q;
        ext_write_d  = ext_write_q;
        ext_dev_d    = ext_dev_q;
        ext_data_d   = ext_data_q;
        rom_addr_d   = rom_addr_q;
        cnt_d        = cnt_q;
        latch_d      = latch_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit_prom) begin
                        if (bus.req_write) begin
                            resp_valid_d = 1'b1;
                            resp_err_d   = 1'b1;
                            resp_data_d  = '0;
                        end else begin
                            rom_addr_d = bus.req_data[ROM_ADDR_W-1:0];
                        end
                    end else if (hit_cons) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        resp_data_d  = bus.req_data;
                    end else if (hit_latch) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b0;
                        if (bus.req_write) begin
                            resp_data_d = bus.req_data;
                            for (int i = 0; i < NUM_LATCH; i++) begin
                                if (latch_idx == DEV_ID_W'(i)) begin
                                    latch_d[i] = bus.req_data;
                                end
                            end
                        end else begin
                            resp_data_d = latch_rd;
                        end
                    end else begin
                        ext_valid_d = 1'b1;
                        ext_write_d = bus.req_write;
                        ext_dev_d   = bus.req_dev;
                        ext_data_d  = bus.req_data;
                        cnt_d       = '0;
                    end
                end
            end
            ROM_RD: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_data_d  = bus.rom_data;
            end
            EXT_WAIT: begin
                if (bus.ext_ack) begin
                    ext_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = ext_write_q ? '0 : bus.ext_rdata;
                end else if (to_expire) begin
                    ext_valid_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_data_d  = '1;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            ext_valid_q  <= 1'b0;
            ext_write_q  <= 1'b0;
            ext_dev_q    <= '0;
            ext_data_q   <= '0;
            rom_addr_q   <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < NUM_LATCH; i++) begin
                latch_q[i] <= '0;
            end
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            ext_valid_q  <= ext_valid_d;
            ext_write_q  <= ext_write_d;
            ext_dev_q    <= ext_dev_d;
            ext_data_q   <= ext_data_d;
            rom_addr_q   <= rom_addr_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < NUM_LATCH; i++) begin
                latch_q[i] <= latch_d[i];
            end
        end
    end

    // Flatten the latch bank onto the output bus.
    always_comb begin
        for (int i = 0; i < NUM_LATCH; i++) begin
            latch_out[i*DATA_W +: DATA_W] = latch_q[i];
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.ext_valid  = ext_valid_q;
    assign bus.ext_write  = ext_write_q;
    assign bus.ext_dev    = ext_dev_q;
    assign bus.ext_data   = ext_data_q;
    assign bus.rom_addr   = rom_addr_q;

endmodule
